// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Minimum number of decimal digits able to hold the largest magnitude of a
  // width-bit operand: 2^width-1 when unsigned, 2^(width-1) when signed.
  function automatic int unsigned digits_needed(int unsigned width, bit is_signed);
    logic [127:0] maxv;
    int unsigned  n;
    maxv = is_signed ? (128'd1 << (width - 1)) : ((128'd1 << width) - 128'd1);
    n = 1;
    while (maxv >= 128'd10) begin
      maxv = maxv / 128'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single BCD digit pre-shift adjust: digits of 5 or more get 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Add 3 when the digit would overflow 9 after doubling.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one operand bit per clock.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    x,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                sign
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  if (WIDTH < 2) begin : g_bad_width
    $error("bin2bcd_seq: WIDTH must be at least 2");
  end
  if (DIGITS < digits_needed(WIDTH, SIGNED)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             sign_q, sign_d;

  logic             neg;
  logic [WIDTH:0]   x_ext;
  logic [WIDTH:0]   mag;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    shifted;
  logic             unused_bits;

  // Magnitude with one spare bit so the most negative operand negates cleanly;
  // the result always fits back into WIDTH unsigned bits.
  always_comb begin
    neg   = SIGNED && x[WIDTH-1];
    x_ext = {neg, x};
    mag   = neg ? (~x_ext + (WIDTH + 1)'(1)) : x_ext;
  end

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    bcd_add3 u_add3 (
      .digit    (scratch_q[4*i+:4]),
      .adjusted (adj[4*i+:4])
    );
  end

  // Adjusted scratch shifted left, pulling in the next operand bit.
  assign shifted     = {adj[BW-2:0], bin_q[WIDTH-1]};
  assign unused_bits = ^{mag[WIDTH], adj[BW-1]};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      sign_q    <= sign_d;
    end
  end

  // Next-state logic; busy/done are computed here so the outputs are registered.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    sign_d    = sign_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          bin_d     = mag[WIDTH-1:0];
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          pend_d    = neg;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        bin_d     = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted;
          sign_d  = pend_q;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign sign = sign_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench: default, signed and 16-bit configurations.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  logic        start_a, busy_a, done_a, sign_a;
  logic [7:0]  x_a;
  logic [11:0] bcd_a;

  logic        start_s, busy_s, done_s, sign_s;
  logic [7:0]  x_s;
  logic [11:0] bcd_s;

  logic        start_w, busy_w, done_w, sign_w;
  logic [15:0] x_w;
  logic [19:0] bcd_w;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0)) u_dut_a (
    .clk (clk), .rst (rst), .start (start_a), .x (x_a),
    .busy (busy_a), .done (done_a), .bcd (bcd_a), .sign (sign_a)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) u_dut_s (
    .clk (clk), .rst (rst), .start (start_s), .x (x_s),
    .busy (busy_s), .done (done_s), .bcd (bcd_s), .sign (sign_s)
  );

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_dut_w (
    .clk (clk), .rst (rst), .start (start_w), .x (x_w),
    .busy (busy_w), .done (done_w), .bcd (bcd_w), .sign (sign_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_s;
      default: return done_w;
    endcase
  endfunction

  // Pulse start for one cycle and count cycles from the start cycle to done.
  task automatic run_conv(input int sel, input logic [15:0] val, output int lat);
    case (sel)
      0:       begin start_a = 1'b1; x_a = val[7:0]; end
      1:       begin start_s = 1'b1; x_s = val[7:0]; end
      default: begin start_w = 1'b1; x_w = val; end
    endcase
    tick();
    lat = 1;
    start_a = 1'b0;
    start_s = 1'b0;
    start_w = 1'b0;
    while (!done_of(sel) && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy_a, done_a, sign_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {busy_a, done_a, sign_a});
    end
    checks++;
    if (bcd_a !== 12'h000) begin
      errors++;
      $display("FAIL reset_bcd_a: got %h want 000", bcd_a);
    end
    checks++;
    if (bcd_s !== 12'h000 || sign_s !== 1'b0 || bcd_w !== 20'h00000) begin
      errors++;
      $display("FAIL reset_other: got %h %b %h want 000 0 00000", bcd_s, sign_s, bcd_w);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_timing_255();
    int busy_bad = 0;
    x_a     = 8'd255;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (busy_a !== 1'b1 || done_a !== 1'b0) busy_bad++;
      tick();
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL busy_window: got %0d bad cycles want 0", busy_bad);
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle9: got done=%b busy=%b want done=1 busy=0", done_a, busy_a);
    end
    checks++;
    if (bcd_a !== 12'h255 || sign_a !== 1'b0) begin
      errors++;
      $display("FAIL bcd_255: got %h sign %b want 255 sign 0", bcd_a, sign_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || bcd_a !== 12'h255) begin
      errors++;
      $display("FAIL done_pulse_hold: got done=%b busy=%b bcd=%h want 0 0 255",
               done_a, busy_a, bcd_a);
    end
  endtask

  task automatic test_small();
    int lat;
    run_conv(0, 16'd0, lat);
    checks++;
    if (lat != 9 || bcd_a !== 12'h000) begin
      errors++;
      $display("FAIL zero: got lat=%0d bcd=%h want lat=9 bcd=000", lat, bcd_a);
    end
    tick();
    run_conv(0, 16'd99, lat);
    checks++;
    if (lat != 9 || bcd_a !== 12'h099) begin
      errors++;
      $display("FAIL ninety_nine: got lat=%0d bcd=%h want lat=9 bcd=099", lat, bcd_a);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int n;
    int extra = 0;
    x_a     = 8'd123;
    start_a = 1'b1;
    tick();
    n       = 1;
    start_a = 1'b0;
    tick();
    tick();
    n       = 3;
    start_a = 1'b1;
    x_a     = 8'd45;
    tick();
    n++;
    start_a = 1'b0;
    while (!done_a && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 9 || bcd_a !== 12'h123) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d bcd=%h want lat=9 bcd=123", n, bcd_a);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done_a) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL no_extra_done: got %0d dones want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vals [3] = '{8'd10, 8'd20, 8'd30};
    logic [11:0] exps [3] = '{12'h010, 12'h020, 12'h030};
    int n;
    x_a     = vals[0];
    start_a = 1'b1;
    for (int j = 0; j < 3; j++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!done_a && n < 40);
      checks++;
      if (n != 9 || bcd_a !== exps[j]) begin
        errors++;
        $display("FAIL back_to_back_%0d: got period=%0d bcd=%h want period=9 bcd=%h",
                 j, n, bcd_a, exps[j]);
      end
      if (j < 2) x_a = vals[j+1];
      else start_a = 1'b0;
    end
    tick();
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: got done=%b busy=%b want 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int extra = 0;
    x_a     = 8'd77;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || bcd_a !== 12'h000) begin
      errors++;
      $display("FAIL abort_state: got busy=%b done=%b bcd=%h want 0 0 000",
               busy_a, done_a, bcd_a);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_a) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d dones want 0", extra);
    end
    run_conv(0, 16'd200, lat);
    checks++;
    if (lat != 9 || bcd_a !== 12'h200) begin
      errors++;
      $display("FAIL after_abort: got lat=%0d bcd=%h want lat=9 bcd=200", lat, bcd_a);
    end
    tick();
  endtask

  task automatic test_signed();
    int lat;
    run_conv(1, 16'h0080, lat);
    checks++;
    if (lat != 9 || sign_s !== 1'b1 || bcd_s !== 12'h128) begin
      errors++;
      $display("FAIL signed_min: got lat=%0d sign=%b bcd=%h want lat=9 sign=1 bcd=128",
               lat, sign_s, bcd_s);
    end
    tick();
    run_conv(1, 16'h00FF, lat);
    checks++;
    if (sign_s !== 1'b1 || bcd_s !== 12'h001) begin
      errors++;
      $display("FAIL signed_m1: got sign=%b bcd=%h want sign=1 bcd=001", sign_s, bcd_s);
    end
    tick();
    run_conv(1, 16'h007F, lat);
    checks++;
    if (sign_s !== 1'b0 || bcd_s !== 12'h127) begin
      errors++;
      $display("FAIL signed_max: got sign=%b bcd=%h want sign=0 bcd=127", sign_s, bcd_s);
    end
    tick();
  endtask

  task automatic test_wide();
    int lat;
    run_conv(2, 16'd65535, lat);
    checks++;
    if (lat != 17 || bcd_w !== 20'h65535 || sign_w !== 1'b0) begin
      errors++;
      $display("FAIL wide_max: got lat=%0d bcd=%h sign=%b want lat=17 bcd=65535 sign=0",
               lat, bcd_w, sign_w);
    end
    tick();
    run_conv(2, 16'd40960, lat);
    checks++;
    if (bcd_w !== 20'h40960) begin
      errors++;
      $display("FAIL wide_mid: got bcd=%h want 40960", bcd_w);
    end
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_s = 1'b0;
    start_w = 1'b0;
    x_a     = '0;
    x_s     = '0;
    x_w     = '0;
    test_reset();
    test_timing_255();
    test_small();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_signed();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It takes a WIDTH-bit unsigned or two's-complement value on a start strobe and produces a DIGITS-digit packed BCD result with a sign flag and a done pulse. It sits between counter/ALU datapaths and the seven-segment display drivers, and replaces the purely combinational divide/modulo converter at widths where that does not close timing.

## Interface
- WIDTH, 8: binary input width, ≥2.
- DIGITS, 3: BCD digits produced. Elaboration fails unless 10^DIGITS > 2^WIDTH − 1 (unsigned) or ≥ 2^(WIDTH−1) (signed).
- SIGNED, 0: 1 means x is two's complement; the magnitude is converted and the sign is reported separately.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion of x; sampled only when accepted (see Operation).
- x  in  WIDTH  binary operand; captured on the accepting edge only.
- busy  out  1  high while converting (SHIFT state).
- done  out  1  one-cycle pulse; bcd and sign are valid for the new result.
- bcd  out  4*DIGITS  packed BCD, most significant digit in the top nibble.
- sign  out  1  1 when SIGNED=1 and x was negative; otherwise 0.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset: state=IDLE, busy=0, done=0, bcd=0, sign=0, internal scratch and counter cleared.
- Acceptance: start=1 in IDLE or DONE is accepted. Start during SHIFT is ignored; no queuing.
- On acceptance:
  - Load the magnitude into the shift register: |x| if SIGNED and x[WIDTH−1]=1, else x.
  - Zero the BCD scratch and set the bit counter to WIDTH.
  - Latch the pending sign and go to SHIFT.
- Magnitude arithmetic: one extra bit of width, so the most negative value converts correctly (8-bit 0x80 → 128).
- SHIFT, each edge:
  - For every scratch digit ≥5, add 3 (4-bit, no carry between digits).
  - Shift {scratch, binary} left by 1.
  - Decrement the counter.
- After the WIDTH-th shift, copy scratch to bcd, copy the pending sign to sign, and go to DONE.
- DONE lasts exactly one cycle with done=1. Next state is SHIFT if start=1, else IDLE.
- bcd and sign hold their last result until the next completion. They do not change at acceptance.
- Reset mid-SHIFT aborts the conversion: no done, outputs return to their reset values.

## Timing
- Start accepted at edge k:
  - busy=1 after edges k … k+WIDTH−1.
  - done=1 and bcd valid after edge k+WIDTH.
  - Latency is WIDTH+1 cycles from the start cycle to the done cycle.
- Back-to-back: start held high yields one result every WIDTH+1 cycles.
- done and busy are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Critical path is one add-3 stage plus the shift, independent of WIDTH.

## Structure
- Package bin2bcd_pkg:
  - state enum: IDLE, SHIFT, DONE.
  - function digits_needed(width, signed), used for the elaboration check.
- Sub-module bcd_add3: combinational 4-bit digit adjust (d≥5 ? d+3 : d), instantiated DIGITS times in a generate loop.
- Counter width: $clog2(WIDTH+1).

## Test plan
- Defaults, x=255, start pulse at cycle 0 → done at cycle 9, bcd=0x255, sign=0. busy high cycles 1–8.
- Defaults, x=0 → bcd=0x000. Then x=99 → bcd=0x099.
- Start re-asserted at cycle 3 of a conversion with x changed → ignored; the first result is reported, then no extra done.
- start held high with x stepping 10, 20, 30 → done every 9 cycles, bcd 0x010, 0x020, 0x030.
- rst asserted at cycle 4 of a conversion → no done; bcd=0, busy=0 the next cycle; a fresh start converts correctly.
- SIGNED=1 WIDTH=8: x=0x80 → sign=1, bcd=0x128; x=0xFF → sign=1, bcd=0x001.
- WIDTH=16 DIGITS=5: x=65535 → bcd=0x65535 after 17 cycles.
